// File: rtl/divisor_secuencial.sv
// Sequential signed fixed-point divider, restoring, one quotient bit per clock.
// Define DIVISOR_ROUND_EN for round-half-away-from-zero (one extra iteration).
module divisor_secuencial #(
    parameter int N    = 25,
    parameter int FRAC = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y,
    output logic         busy,
    output logic         done,
    output logic         overflow,
    output logic         div0
);

`ifdef DIVISOR_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    // Quotient bits produced by CALC (one guard bit when rounding).
    localparam int W  = N + FRAC + RND;
    localparam int CW = $clog2(W + 1);

    localparam logic [N-1:0] Y_MAX   = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] Y_MIN   = {1'b1, {(N-1){1'b0}}};
    localparam logic [W-1:0] LIM_POS = {{(W-N){1'b0}}, Y_MAX};
    localparam logic [W-1:0] LIM_NEG = {{(W-N){1'b0}}, Y_MIN};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [W-1:0]  r_quo;
    logic [N:0]    r_rem;
    logic [N-1:0]  r_b;
    logic [CW-1:0] r_cnt;
    logic          r_sign;
    logic          r_sa;
    logic          r_bz;

    logic [N-1:0]  r_y;
    logic          r_busy;
    logic          r_done;
    logic          r_ovf;
    logic          r_div0;

    logic [N-1:0]  w_abs_a;
    logic [N-1:0]  w_abs_b;
    logic [N+1:0]  w_shift;
    logic          w_ge;
    logic [N:0]    w_sub;
    logic          w_last;

    logic [W-1:0]  w_mag;
    logic [W-1:0]  w_lim;
    logic          w_ovf;
    logic [N-1:0]  w_mag_n;
    logic [N-1:0]  w_y;

    // Operand magnitudes; the most negative value maps to 2^(N-1) unsigned.
    always_comb begin
        w_abs_a = a[N-1] ? (~a + 1'b1) : a;
        w_abs_b = b[N-1] ? (~b + 1'b1) : b;
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        w_shift = {r_rem, r_quo[W-1]};
        w_ge    = (w_shift >= {2'b00, r_b});
        w_sub   = w_shift[N:0] - {1'b0, r_b};
        w_last  = (r_cnt == CW'(W - 1));
    end

    // Final magnitude, saturation against the limit of the result sign.
    always_comb begin
`ifdef DIVISOR_ROUND_EN
        w_mag = {1'b0, r_quo[W-1:1]} + {{(W-1){1'b0}}, r_quo[0]};
`else
        w_mag = r_quo;
`endif
        w_lim   = r_sign ? LIM_NEG : LIM_POS;
        w_ovf   = (w_mag > w_lim);
        w_mag_n = w_ovf ? w_lim[N-1:0] : w_mag[N-1:0];
        w_y     = (r_sign && (w_mag_n != '0)) ? (~w_mag_n + 1'b1) : w_mag_n;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> CALC (W steps) -> FIX -> DONE -> IDLE.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (start) w_state_nxt = S_CALC;
            S_CALC: if (w_last) w_state_nxt = S_FIX;
            S_FIX:  w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_quo  <= '0;
            r_rem  <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_sign <= 1'b0;
            r_sa   <= 1'b0;
            r_bz   <= 1'b0;
            r_y    <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
            r_div0 <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_quo  <= {w_abs_a, {(FRAC+RND){1'b0}}};
                        r_rem  <= '0;
                        r_b    <= w_abs_b;
                        r_cnt  <= '0;
                        r_sign <= a[N-1] ^ b[N-1];
                        r_sa   <= a[N-1];
                        r_bz   <= (b == '0);
                        r_busy <= 1'b1;
                    end
                end
                S_CALC: begin
                    r_rem <= w_ge ? w_sub : w_shift[N:0];
                    r_quo <= {r_quo[W-2:0], w_ge};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    if (r_bz) begin
                        r_y    <= r_sa ? Y_MIN : Y_MAX;
                        r_ovf  <= 1'b1;
                        r_div0 <= 1'b1;
                    end else begin
                        r_y    <= w_y;
                        r_ovf  <= w_ovf;
                        r_div0 <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign y        = r_y;
    assign busy     = r_busy;
    assign done     = r_done;
    assign overflow = r_ovf;
    assign div0     = r_div0;

endmodule

// File: tb/tb_divisor_secuencial.sv
// Self-checking bench for divisor_secuencial (scoreboard of expected results).
// Expectations follow DIVISOR_ROUND_EN when it is defined for the build.
module tb_divisor_secuencial;

    localparam int N    = 25;
    localparam int FRAC = 10;
`ifdef DIVISOR_ROUND_EN
    localparam int LAT = 38;
`else
    localparam int LAT = 37;
`endif

    typedef struct packed {
        logic [N-1:0] y;
        logic         ovf;
        logic         dz;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] y;
    logic         busy;
    logic         done;
    logic         overflow;
    logic         div0;

    exp_t sb[$];
    int   n_cmp;
    int   n_err;

    divisor_secuencial #(.N(N), .FRAC(FRAC)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .y        (y),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .div0     (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] ma, input logic [N-1:0] mb);
        exp_t   e;
        longint av, bv, na, nb, q, lim;
        bit     neg;
        av = longint'($signed(ma));
        bv = longint'($signed(mb));
        e  = '0;
        if (bv == 0) begin
            e.dz  = 1'b1;
            e.ovf = 1'b1;
            e.y   = (av < 0) ? 25'h1000000 : 25'h0FFFFFF;
            return e;
        end
        neg = (av < 0) ^ (bv < 0);
        na  = (av < 0) ? -av : av;
        nb  = (bv < 0) ? -bv : bv;
`ifdef DIVISOR_ROUND_EN
        q = (((na << (FRAC + 1)) / nb) + 1) >> 1;
`else
        q = (na << FRAC) / nb;
`endif
        lim = neg ? (longint'(1) << (N - 1)) : ((longint'(1) << (N - 1)) - 1);
        if (q > lim) begin
            e.ovf = 1'b1;
            q     = lim;
        end
        e.y = N'(neg ? -q : q);
        return e;
    endfunction

    task automatic run_div(input logic [N-1:0] ta, input logic [N-1:0] tbv,
                           input bit inj);
        exp_t e;
        int   cnt;
        bit   got;
        sb.push_back(model(ta, tbv));
        a     = ta;
        b     = tbv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = N'($urandom);
        b     = N'($urandom);
        check("busy_after_start", 64'(busy), 64'd1);
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < 100) begin
            start = (inj && cnt == 5);
            @(posedge clk);
            #1;
            start = 1'b0;
            cnt++;
            if (done) got = 1'b1;
        end
        check("latency", 64'(cnt), 64'(LAT));
        e = sb.pop_front();
        if (got) begin
            check("y", 64'(y), 64'(e.y));
            check("overflow", 64'(overflow), 64'(e.ovf));
            check("div0", 64'(div0), 64'(e.dz));
            check("busy_at_done", 64'(busy), 64'd0);
            @(posedge clk);
            #1;
            check("done_pulse", 64'(done), 64'd0);
            check("y_held", 64'(y), 64'(e.y));
        end
    endtask

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        int           nd;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_y", 64'(y), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_div0", 64'(div0), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_div(25'd3072, 25'd1024, 1'b0);
        run_div(25'd2048, 25'd3072, 1'b0);
        run_div(25'h1FFFC00, 25'd2048, 1'b0);
        run_div(25'd1024, 25'h1FFF400, 1'b0);
        run_div(25'h0FFFFFF, 25'd1, 1'b0);
        run_div(25'h1000000, 25'd1, 1'b0);
        run_div(25'd5, 25'd0, 1'b0);
        run_div(25'h1FFFFFB, 25'd0, 1'b0);
        run_div(25'd0, 25'h1FFFC00, 1'b0);
        run_div(25'd3072, 25'd1024, 1'b1);

        for (int i = 0; i < 8; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            if (i < 4) rb = N'($signed(rb) >>> 10);
            run_div(ra, rb, 1'b0);
        end

        run_div(25'd5, 25'd0, 1'b0);
        a     = 25'd4096;
        b     = 25'd1024;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_y", 64'(y), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_ovf", 64'(overflow), 64'd0);
        check("midrst_div0", 64'(div0), 64'd0);
        nd = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) nd++;
        end
        check("midrst_discard", 64'(nd), 64'd0);
        rst_n = 1'b1;
        run_div(25'h1FFF400, 25'h1FFFC00, 1'b0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
